// File: rtl/sifh_pkg.sv
// Shared definitions for the two-pass SiFH histogram controller: state encoding,
// default geometry, width helpers and the saturating count increment.
package sifh_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR1,
        S_BUILD1,
        S_SCAN1,
        S_CLEAR2,
        S_BUILD2,
        S_SCAN2
    } state_t;

    localparam int DEF_PIXELS = 4;
    localparam int DEF_HALF_W = 4;
    localparam int DEF_CNT_W  = 8;
    localparam int DEF_EVENTS = 1024;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << r) < v) r++;
        end
        return r;
    endfunction

    // A single pixel still needs a 1-bit pixel field on the ports.
    function automatic int pix_width(input int pixels);
        return (pixels > 2) ? clog2(pixels) : 1;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
        logic [31:0] max_v;
        max_v = (32'd1 << w) - 32'd1;
        return (v >= max_v) ? max_v : v + 32'd1;
    endfunction

endpackage

// File: rtl/sifh_rmw_incr.sv
// Two-stage read-modify-write incrementer for histogram RAM with one-cycle
// write-to-read forwarding so back-to-back hits on one bin never lose a count.
module sifh_rmw_incr
    import sifh_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              res,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_addr,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [CNT_W-1:0]  rdata,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [CNT_W-1:0]  wr_data,
    output logic              busy
);

    logic              s1_valid_q, s1_valid_d;
    logic [ADDR_W-1:0] s1_addr_q, s1_addr_d;
    logic              lw_valid_q, lw_valid_d;
    logic [ADDR_W-1:0] lw_addr_q, lw_addr_d;
    logic [CNT_W-1:0]  lw_data_q, lw_data_d;
    logic [CNT_W-1:0]  base;

    always_comb begin
        rd_en      = in_valid;
        rd_addr    = in_valid ? in_addr : '0;
        s1_valid_d = in_valid;
        s1_addr_d  = in_addr;
        // The RAM returns old data when the read collides with last cycle's write.
        base       = (lw_valid_q && (lw_addr_q == s1_addr_q)) ? lw_data_q : rdata;
        wr_en      = s1_valid_q;
        wr_addr    = s1_valid_q ? s1_addr_q : '0;
        wr_data    = s1_valid_q ? CNT_W'(sat_inc(32'(base), CNT_W)) : '0;
        lw_valid_d = s1_valid_q;
        lw_addr_d  = s1_addr_q;
        lw_data_d  = wr_data;
        busy       = s1_valid_q;
    end

    always_ff @(posedge clk) begin
        if (res) begin
            s1_valid_q <= 1'b0;
            s1_addr_q  <= '0;
            lw_valid_q <= 1'b0;
            lw_addr_q  <= '0;
            lw_data_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_addr_q  <= s1_addr_d;
            lw_valid_q <= lw_valid_d;
            lw_addr_q  <= lw_addr_d;
            lw_data_q  <= lw_data_d;
        end
    end

endmodule

// File: rtl/sifh_two_pass_ctrl.sv
// Two-pass focused-histogram controller: coarse histogram and peak per pixel,
// then a fine histogram restricted to each pixel's coarse-peak window.
module sifh_two_pass_ctrl
    import sifh_pkg::*;
#(
    parameter int PIXELS = DEF_PIXELS,
    parameter int HALF_W = DEF_HALF_W,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int EVENTS = DEF_EVENTS,
    localparam int PIX_W  = pix_width(PIXELS),
    localparam int ADDR_W = PIX_W + HALF_W,
    localparam int BIN_W  = 2 * HALF_W
) (
    input  logic              clk,
    input  logic              res,
    input  logic              start,
    input  logic              tdc_valid,
    input  logic [PIX_W-1:0]  tdc_pixel,
    input  logic [BIN_W-1:0]  tdc_bin,
    output logic              tdc_ready,
    output logic              wrEn,
    output logic [ADDR_W-1:0] waddr,
    output logic              wEnable,
    output logic [CNT_W-1:0]  wdata,
    output logic [ADDR_W-1:0] raddr,
    output logic              rEnable,
    input  logic [CNT_W-1:0]  rdata,
    output logic              peak_valid,
    output logic [PIX_W-1:0]  peak_pixel,
    output logic [BIN_W-1:0]  peak_bin,
    output logic [CNT_W-1:0]  peak_count,
    output logic              busy,
    output logic              done
);

    localparam int DEPTH = PIXELS << HALF_W;
    localparam int AC_W  = ADDR_W + 1;
    localparam int EV_W  = clog2(EVENTS + 1);
    localparam logic [AC_W-1:0]   DEPTH_A   = AC_W'(DEPTH);
    localparam logic [AC_W-1:0]   LAST_A    = AC_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [EV_W-1:0]   EVENTS_C  = EV_W'(EVENTS);

    state_t            state_q, state_d;
    logic [AC_W-1:0]   addr_q, addr_d;
    logic [EV_W-1:0]   ev_q, ev_d;
    logic [HALF_W-1:0] peak_tbl_q [PIXELS];
    logic [HALF_W-1:0] peak_tbl_d [PIXELS];
    logic              rd_v_q, rd_v_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [CNT_W-1:0]  max_q, max_d;
    logic [HALF_W-1:0] best_q, best_d;
    logic              pv_q, pv_d, done_q, done_d;
    logic [PIX_W-1:0]  pp_q, pp_d;
    logic [BIN_W-1:0]  pb_q, pb_d;
    logic [CNT_W-1:0]  pc_q, pc_d;

    logic              is_clear, is_build, is_scan, accept, scan_rd;
    logic [HALF_W-1:0] ev_coarse, ev_fine, cur_bin, new_best;
    logic [PIX_W-1:0]  cur_pix;
    logic [CNT_W-1:0]  new_max;
    logic              rmw_in_valid, rmw_rd_en, rmw_wr_en, rmw_busy;
    logic [ADDR_W-1:0] rmw_in_addr, rmw_rd_addr, rmw_wr_addr;
    logic [CNT_W-1:0]  rmw_wr_data;

    sifh_rmw_incr #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_rmw (
        .clk      (clk),
        .res      (res),
        .in_valid (rmw_in_valid),
        .in_addr  (rmw_in_addr),
        .rd_en    (rmw_rd_en),
        .rd_addr  (rmw_rd_addr),
        .rdata    (rdata),
        .wr_en    (rmw_wr_en),
        .wr_addr  (rmw_wr_addr),
        .wr_data  (rmw_wr_data),
        .busy     (rmw_busy)
    );

    always_comb begin
        is_clear  = (state_q == S_CLEAR1) || (state_q == S_CLEAR2);
        is_build  = (state_q == S_BUILD1) || (state_q == S_BUILD2);
        is_scan   = (state_q == S_SCAN1) || (state_q == S_SCAN2);
        tdc_ready = is_build && (ev_q < EVENTS_C);
        wrEn      = is_build;
        busy      = (state_q != S_IDLE);
        accept    = tdc_valid && tdc_ready;
        ev_coarse = tdc_bin[BIN_W-1:HALF_W];
        ev_fine   = tdc_bin[HALF_W-1:0];
        // Second-pass events outside the pixel's coarse window still count toward EVENTS.
        rmw_in_valid = accept && ((state_q == S_BUILD1) || (ev_coarse == peak_tbl_q[tdc_pixel]));
        rmw_in_addr  = {tdc_pixel, (state_q == S_BUILD1) ? ev_coarse : ev_fine};
        scan_rd      = is_scan && (addr_q < DEPTH_A);

        wEnable = is_clear || rmw_wr_en;
        waddr   = is_clear ? addr_q[ADDR_W-1:0] : rmw_wr_addr;
        wdata   = is_clear ? '0 : rmw_wr_data;
        rEnable = scan_rd || rmw_rd_en;
        raddr   = scan_rd ? addr_q[ADDR_W-1:0] : rmw_rd_addr;

        cur_bin = rd_addr_q[HALF_W-1:0];
        cur_pix = rd_addr_q[ADDR_W-1:HALF_W];
        // Strictly-greater update keeps the lowest bin on ties.
        if ((cur_bin == '0) || (rdata > max_q)) begin
            new_max  = rdata;
            new_best = cur_bin;
        end else begin
            new_max  = max_q;
            new_best = best_q;
        end

        peak_tbl_d = peak_tbl_q;
        max_d      = rd_v_q ? new_max : max_q;
        best_d     = rd_v_q ? new_best : best_q;
        pv_d       = 1'b0;
        pp_d       = '0;
        pb_d       = '0;
        pc_d       = '0;
        if (rd_v_q && (cur_bin == '1)) begin
            if (state_q == S_SCAN1) peak_tbl_d[cur_pix] = new_best;
            if (state_q == S_SCAN2) begin
                pv_d = 1'b1;
                pp_d = cur_pix;
                pb_d = {peak_tbl_q[cur_pix], new_best};
                pc_d = new_max;
            end
        end
        rd_v_d    = scan_rd;
        rd_addr_d = addr_q[ADDR_W-1:0];

        state_d = state_q;
        addr_d  = addr_q;
        ev_d    = is_build ? ev_q + EV_W'(accept) : '0;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                addr_d = '0;
                if (start) state_d = S_CLEAR1;
            end
            S_CLEAR1, S_CLEAR2: begin
                addr_d = addr_q + AC_W'(1);
                if (addr_q == LAST_A) begin
                    addr_d  = '0;
                    state_d = (state_q == S_CLEAR1) ? S_BUILD1 : S_BUILD2;
                end
            end
            S_BUILD1, S_BUILD2: begin
                if ((ev_q == EVENTS_C) && !rmw_busy) begin
                    addr_d  = '0;
                    state_d = (state_q == S_BUILD1) ? S_SCAN1 : S_SCAN2;
                end
            end
            S_SCAN1, S_SCAN2: begin
                if (scan_rd) addr_d = addr_q + AC_W'(1);
                if (rd_v_q && (rd_addr_q == LAST_ADDR)) begin
                    addr_d  = '0;
                    state_d = (state_q == S_SCAN1) ? S_CLEAR2 : S_IDLE;
                    done_d  = (state_q == S_SCAN2);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            ev_q      <= '0;
            rd_v_q    <= 1'b0;
            rd_addr_q <= '0;
            max_q     <= '0;
            best_q    <= '0;
            pv_q      <= 1'b0;
            pp_q      <= '0;
            pb_q      <= '0;
            pc_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            ev_q      <= ev_d;
            rd_v_q    <= rd_v_d;
            rd_addr_q <= rd_addr_d;
            max_q     <= max_d;
            best_q    <= best_d;
            pv_q      <= pv_d;
            pp_q      <= pp_d;
            pb_q      <= pb_d;
            pc_q      <= pc_d;
            done_q    <= done_d;
        end
    end

    for (genvar gi = 0; gi < PIXELS; gi++) begin : g_peak_tbl
        always_ff @(posedge clk) begin
            if (res) peak_tbl_q[gi] <= '0;
            else     peak_tbl_q[gi] <= peak_tbl_d[gi];
        end
    end

    assign peak_valid = pv_q;
    assign peak_pixel = pp_q;
    assign peak_bin   = pb_q;
    assign peak_count = pc_q;
    assign done       = done_q;

endmodule
